// File: rtl/uart_accumulator_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_accumulator_arbiter
// Description : Shares one command accumulator between two UART byte sources
//               (source 0 = BLE RX, source 1 = host RX). Each source has a
//               small byte FIFO. One source is granted per command, and its
//               bytes are replayed as timed accumulate strobes. The grant is
//               held until the accumulator signals done (or a watchdog
//               expires), then a one-cycle command-complete event is issued.
// Ports       : clk, reset (async, active-high)
//               rx_data0/rx_valid0   BLE byte + one-cycle valid
//               rx_data1/rx_valid1   host byte + one-cycle valid
//               acc_done/acc_error/acc_size   accumulator status inputs
//               acc_data/acc_accumulate/acc_ble_side   accumulator drive
//               cmd_valid/cmd_src/cmd_err/cmd_timeout/cmd_size   completion
//               overflow[1:0]  per-source dropped-byte pulse
//               busy           grant held
// Revision    : 1.0 - initial release
// ============================================================================
module uart_accumulator_arbiter #(
    parameter int FIFO_DEPTH    = 4,
    parameter int STROBE_CYCLES = 4,
    parameter int GAP_CYCLES    = 4,
    parameter int WATCHDOG      = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data0,
    input  logic       rx_valid0,
    input  logic [7:0] rx_data1,
    input  logic       rx_valid1,
    input  logic       acc_done,
    input  logic       acc_error,
    input  logic [7:0] acc_size,
    output logic [7:0] acc_data,
    output logic       acc_accumulate,
    output logic       acc_ble_side,
    output logic       cmd_valid,
    output logic       cmd_src,
    output logic       cmd_err,
    output logic       cmd_timeout,
    output logic [7:0] cmd_size,
    output logic [1:0] overflow,
    output logic       busy
);
    localparam int c_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [c_AW:0]   c_DEPTH   = (c_AW + 1)'(FIFO_DEPTH);
    localparam logic [c_AW:0]   c_CNT_ONE = (c_AW + 1)'(1);
    localparam logic [c_AW-1:0] c_PTR_ONE = c_AW'(1);

    localparam int c_SG_MAX = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
    localparam int c_CMAX   = (WATCHDOG > c_SG_MAX) ? WATCHDOG : c_SG_MAX;
    localparam int c_CW     = $clog2(c_CMAX + 1);
    localparam logic [c_CW-1:0] c_STROBE_LAST = c_CW'(STROBE_CYCLES - 1);
    localparam logic [c_CW-1:0] c_GAP_LAST    = c_CW'(GAP_CYCLES - 1);
    localparam logic [c_CW-1:0] c_WD_LAST     = c_CW'(WATCHDOG - 1);
    localparam logic [c_CW-1:0] c_ONE         = c_CW'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_STROBE    = 3'd1,
        S_GAP       = 3'd2,
        S_WAIT_BYTE = 3'd3,
        S_COMPLETE  = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Per-source byte FIFOs
    // ------------------------------------------------------------------
    logic [1:0] rx_valid_w;
    logic [7:0] rx_data_w [2];
    logic [1:0] pop;
    logic [1:0] nempty;
    logic [1:0] full;
    logic [7:0] head [2];

    assign rx_valid_w   = {rx_valid1, rx_valid0};
    assign rx_data_w[0] = rx_data0;
    assign rx_data_w[1] = rx_data1;

    generate
        for (genvar g = 0; g < 2; g++) begin : g_fifo
            logic [7:0]      mem_q [FIFO_DEPTH];
            logic [c_AW-1:0] wr_ptr_q;
            logic [c_AW-1:0] rd_ptr_q;
            logic [c_AW:0]   count_q;
            logic            wr_en;

            assign full[g]   = (count_q == c_DEPTH);
            assign nempty[g] = (count_q != '0);
            assign head[g]   = mem_q[rd_ptr_q];
            // A pop in the same cycle frees the slot, so a full FIFO still
            // accepts the incoming byte.
            assign wr_en     = rx_valid_w[g] & (~full[g] | pop[g]);

            always_ff @(posedge clk) begin
                if (wr_en) begin
                    mem_q[wr_ptr_q] <= rx_data_w[g];
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    count_q  <= '0;
                end else begin
                    if (wr_en) begin
                        wr_ptr_q <= wr_ptr_q + c_PTR_ONE;
                    end
                    if (pop[g]) begin
                        rd_ptr_q <= rd_ptr_q + c_PTR_ONE;
                    end
                    case ({wr_en, pop[g]})
                        2'b10:   count_q <= count_q + c_CNT_ONE;
                        2'b01:   count_q <= count_q - c_CNT_ONE;
                        default: count_q <= count_q;
                    endcase
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Grant FSM
    // ------------------------------------------------------------------
    state_t          state_q, state_d;
    logic            grant_q, grant_d;
    logic            last_q, last_d;
    logic            done_seen_q, done_seen_d;
    logic [c_CW-1:0] cnt_q, cnt_d;
    logic [7:0]      data_q, data_d;
    logic            side_q, side_d;
    logic            acc_done_q;
    logic            timeout_d;
    logic            grant_sel;
    logic [1:0]      overflow_q;
    logic            cmd_valid_q, cmd_src_q, cmd_err_q, cmd_timeout_q;
    logic [7:0]      cmd_size_q;

    // On a tie the source not served last wins; otherwise the only
    // non-empty source is chosen.
    assign grant_sel = (&nempty) ? ~last_q : nempty[1];

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        side_d      = side_q;
        done_seen_d = done_seen_q;
        pop         = 2'b00;
        timeout_d   = 1'b0;

        // Only a rising edge of done counts; include the current cycle's
        // edge so a late rise is not missed by the decision below.
        if (state_q != S_IDLE && acc_done && !acc_done_q) begin
            done_seen_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (acc_done && (|nempty)) begin
                    grant_d         = grant_sel;
                    pop[grant_sel]  = 1'b1;
                    data_d          = head[grant_sel];
                    side_d          = ~grant_sel;
                    done_seen_d     = 1'b0;
                    cnt_d           = '0;
                    state_d         = S_STROBE;
                end
            end
            S_STROBE: begin
                if (cnt_q == c_STROBE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + c_ONE;
                end
            end
            S_GAP: begin
                if (cnt_q == c_GAP_LAST) begin
                    cnt_d = '0;
                    if (done_seen_d) begin
                        state_d = S_COMPLETE;
                    end else if (nempty[grant_q]) begin
                        pop[grant_q] = 1'b1;
                        data_d       = head[grant_q];
                        state_d      = S_STROBE;
                    end else begin
                        state_d = S_WAIT_BYTE;
                    end
                end else begin
                    cnt_d = cnt_q + c_ONE;
                end
            end
            S_WAIT_BYTE: begin
                if (done_seen_d) begin
                    cnt_d   = '0;
                    state_d = S_COMPLETE;
                end else if (nempty[grant_q]) begin
                    pop[grant_q] = 1'b1;
                    data_d       = head[grant_q];
                    cnt_d        = '0;
                    state_d      = S_STROBE;
                end else if (cnt_q == c_WD_LAST) begin
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                    state_d   = S_COMPLETE;
                end else begin
                    cnt_d = cnt_q + c_ONE;
                end
            end
            S_COMPLETE: begin
                last_d  = grant_q;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            grant_q       <= 1'b0;
            last_q        <= 1'b1;
            done_seen_q   <= 1'b0;
            cnt_q         <= '0;
            data_q        <= 8'h00;
            side_q        <= 1'b0;
            acc_done_q    <= 1'b0;
            overflow_q    <= 2'b00;
            cmd_valid_q   <= 1'b0;
            cmd_src_q     <= 1'b0;
            cmd_err_q     <= 1'b0;
            cmd_timeout_q <= 1'b0;
            cmd_size_q    <= 8'h00;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            done_seen_q <= done_seen_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            side_q      <= side_d;
            acc_done_q  <= acc_done;
            overflow_q  <= rx_valid_w & full & ~pop;
            // Completion fields are captured on entry to COMPLETE so that
            // cmd_valid is high exactly during the COMPLETE cycle.
            cmd_valid_q <= (state_d == S_COMPLETE);
            if (state_d == S_COMPLETE) begin
                cmd_src_q     <= grant_q;
                cmd_size_q    <= acc_size;
                cmd_err_q     <= acc_error | timeout_d;
                cmd_timeout_q <= timeout_d;
            end
        end
    end

    assign acc_data       = data_q;
    assign acc_accumulate = (state_q == S_STROBE);
    assign acc_ble_side   = side_q;
    assign cmd_valid      = cmd_valid_q;
    assign cmd_src        = cmd_src_q;
    assign cmd_err        = cmd_err_q;
    assign cmd_timeout    = cmd_timeout_q;
    assign cmd_size       = cmd_size_q;
    assign overflow       = overflow_q;
    assign busy           = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_accumulator_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_accumulator_arbiter
// Description : Directed self-checking bench for uart_accumulator_arbiter
//               with a small behavioural accumulator model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_accumulator_arbiter;
    localparam int FIFO_DEPTH    = 4;
    localparam int STROBE_CYCLES = 4;
    localparam int GAP_CYCLES    = 4;
    localparam int WATCHDOG      = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data0, rx_data1;
    logic       rx_valid0, rx_valid1;
    logic       acc_done;
    logic       acc_error = 1'b0;
    logic [7:0] acc_size;
    logic [7:0] acc_data;
    logic       acc_accumulate, acc_ble_side;
    logic       cmd_valid, cmd_src, cmd_err, cmd_timeout;
    logic [7:0] cmd_size;
    logic [1:0] overflow;
    logic       busy;

    uart_accumulator_arbiter #(
        .FIFO_DEPTH   (FIFO_DEPTH),
        .STROBE_CYCLES(STROBE_CYCLES),
        .GAP_CYCLES   (GAP_CYCLES),
        .WATCHDOG     (WATCHDOG)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .rx_data0      (rx_data0),
        .rx_valid0     (rx_valid0),
        .rx_data1      (rx_data1),
        .rx_valid1     (rx_valid1),
        .acc_done      (acc_done),
        .acc_error     (acc_error),
        .acc_size      (acc_size),
        .acc_data      (acc_data),
        .acc_accumulate(acc_accumulate),
        .acc_ble_side  (acc_ble_side),
        .cmd_valid     (cmd_valid),
        .cmd_src       (cmd_src),
        .cmd_err       (cmd_err),
        .cmd_timeout   (cmd_timeout),
        .cmd_size      (cmd_size),
        .overflow      (overflow),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // ------------------------------------------------------------------
    // Accumulator model: done drops on each strobe; it rises two cycles
    // after a BLE 0x0D or after the fourth host byte, reporting size 2.
    // ------------------------------------------------------------------
    logic [8:0] log_q [$];
    int         len_q [$];
    int         m_cnt, m_dly, hi_cnt;
    logic       prev_acc;

    always begin
        @(posedge clk);
        #1;
        if (reset) begin
            acc_done = 1'b1;
            acc_size = 8'h00;
            m_cnt    = 0;
            m_dly    = 0;
            hi_cnt   = 0;
            prev_acc = 1'b0;
        end else begin
            if (acc_accumulate) hi_cnt++;
            if (acc_accumulate && !prev_acc) begin
                log_q.push_back({acc_ble_side, acc_data});
                m_cnt++;
                acc_done = 1'b0;
                acc_size = 8'h00;
                if ((acc_ble_side && acc_data == 8'h0D) || (!acc_ble_side && m_cnt == 4))
                    m_dly = 2;
            end else if (m_dly != 0) begin
                m_dly--;
                if (m_dly == 0) begin
                    acc_done = 1'b1;
                    acc_size = 8'h02;
                    m_cnt    = 0;
                end
            end
            if (!acc_accumulate && prev_acc) begin
                len_q.push_back(hi_cnt);
                hi_cnt = 0;
            end
            prev_acc = acc_accumulate;
        end
    end

    // ------------------------------------------------------------------
    // Helpers (all called at negedge)
    // ------------------------------------------------------------------
    task automatic drive(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1);
        rx_valid0 = v0; rx_data0 = d0;
        rx_valid1 = v1; rx_data1 = d1;
        @(negedge clk);
        rx_valid0 = 1'b0;
        rx_valid1 = 1'b0;
    endtask

    task automatic wait_cmd(input string tag, input int budget, output int cyc);
        cyc = 0;
        while (!cmd_valid && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check_eq({tag, "_seen"}, 32'(cmd_valid), 32'd1);
    endtask

    task automatic chk_cmd(input string tag, input logic src, input logic err,
                           input logic to, input logic [7:0] size);
        check_eq({tag, "_src"}, 32'(cmd_src), 32'(src));
        check_eq({tag, "_err"}, 32'(cmd_err), 32'(err));
        check_eq({tag, "_timeout"}, 32'(cmd_timeout), 32'(to));
        check_eq({tag, "_size"}, 32'(cmd_size), 32'(size));
        @(negedge clk);
        check_eq({tag, "_pulse"}, 32'(cmd_valid), 32'd0);
    endtask

    task automatic chk_log(input string tag, input logic side, input logic [7:0] d);
        logic [31:0] got;
        if (log_q.size() == 0) got = 32'hDEAD_BEEF;
        else got = 32'(log_q.pop_front());
        check_eq(tag, got, 32'({side, d}));
    endtask

    initial begin
        int cyc;
        int act;
        reset = 1'b1;
        rx_valid0 = 1'b0; rx_valid1 = 1'b0;
        rx_data0 = 8'h00; rx_data1 = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_accumulate", 32'(acc_accumulate), 32'd0);
        check_eq("rst_data_side", 32'({acc_data, acc_ble_side}), 32'd0);
        check_eq("rst_cmd", 32'({cmd_valid, cmd_src, cmd_err, cmd_timeout, cmd_size}), 32'd0);
        check_eq("rst_ovf_busy", 32'({overflow, busy}), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // BLE command with latency check
        log_q.delete(); len_q.delete();
        drive(1'b1, 8'h41, 1'b0, 8'h00);
        check_eq("ble_lat_idle", 32'(acc_accumulate), 32'd0);
        @(negedge clk);
        check_eq("ble_lat_strobe", 32'(acc_accumulate), 32'd1);
        check_eq("ble_first_data", 32'(acc_data), 32'h41);
        check_eq("ble_side_busy", 32'({acc_ble_side, busy}), 32'd3);
        drive(1'b1, 8'h54, 1'b0, 8'h00);
        drive(1'b1, 8'h0D, 1'b0, 8'h00);
        wait_cmd("ble", 200, cyc);
        chk_cmd("ble", 1'b0, 1'b0, 1'b0, 8'h02);
        check_eq("ble_busy_after", 32'(busy), 32'd0);
        chk_log("ble_b0", 1'b1, 8'h41);
        chk_log("ble_b1", 1'b1, 8'h54);
        chk_log("ble_b2", 1'b1, 8'h0D);
        check_eq("ble_nstrobes", 32'(len_q.size()), 32'd3);
        while (len_q.size() > 0) check_eq("ble_strobe_len", 32'(len_q.pop_front()), 32'(STROBE_CYCLES));

        // Tie with source 0 served last: source 1 goes first
        log_q.delete();
        drive(1'b1, 8'h41, 1'b1, 8'h01);
        drive(1'b1, 8'h54, 1'b1, 8'h02);
        drive(1'b1, 8'h0D, 1'b1, 8'hBE);
        drive(1'b0, 8'h00, 1'b1, 8'hEF);
        wait_cmd("tieB_1st", 200, cyc);
        chk_cmd("tieB_1st", 1'b1, 1'b0, 1'b0, 8'h02);
        wait_cmd("tieB_2nd", 200, cyc);
        chk_cmd("tieB_2nd", 1'b0, 1'b0, 1'b0, 8'h02);
        chk_log("tieB_b0", 1'b0, 8'h01);
        chk_log("tieB_b1", 1'b0, 8'h02);
        chk_log("tieB_b2", 1'b0, 8'hBE);
        chk_log("tieB_b3", 1'b0, 8'hEF);
        chk_log("tieB_b4", 1'b1, 8'h41);
        chk_log("tieB_b5", 1'b1, 8'h54);
        chk_log("tieB_b6", 1'b1, 8'h0D);

        // Host command
        log_q.delete();
        drive(1'b0, 8'h00, 1'b1, 8'h01);
        drive(1'b0, 8'h00, 1'b1, 8'h02);
        drive(1'b0, 8'h00, 1'b1, 8'hBE);
        drive(1'b0, 8'h00, 1'b1, 8'hEF);
        wait_cmd("host", 200, cyc);
        chk_cmd("host", 1'b1, 1'b0, 1'b0, 8'h02);
        chk_log("host_b0", 1'b0, 8'h01);
        chk_log("host_b1", 1'b0, 8'h02);
        chk_log("host_b2", 1'b0, 8'hBE);
        chk_log("host_b3", 1'b0, 8'hEF);
        check_eq("host_log_empty", 32'(log_q.size()), 32'd0);

        // Tie with source 1 served last: source 0 goes first
        log_q.delete();
        drive(1'b1, 8'h41, 1'b1, 8'h01);
        drive(1'b1, 8'h54, 1'b1, 8'h02);
        drive(1'b1, 8'h0D, 1'b1, 8'hBE);
        drive(1'b0, 8'h00, 1'b1, 8'hEF);
        wait_cmd("tieA_1st", 200, cyc);
        chk_cmd("tieA_1st", 1'b0, 1'b0, 1'b0, 8'h02);
        wait_cmd("tieA_2nd", 200, cyc);
        chk_cmd("tieA_2nd", 1'b1, 1'b0, 1'b0, 8'h02);
        chk_log("tieA_b0", 1'b1, 8'h41);
        chk_log("tieA_b1", 1'b1, 8'h54);
        chk_log("tieA_b2", 1'b1, 8'h0D);
        chk_log("tieA_b3", 1'b0, 8'h01);

        // Overflow on source 1 while source 0 holds the grant
        log_q.delete();
        drive(1'b1, 8'h41, 1'b0, 8'h00);
        drive(1'b1, 8'h54, 1'b0, 8'h00);
        drive(1'b1, 8'h0D, 1'b0, 8'h00);
        drive(1'b0, 8'h00, 1'b1, 8'h01);
        check_eq("ovf_w1", 32'(overflow), 32'd0);
        drive(1'b0, 8'h00, 1'b1, 8'h02);
        check_eq("ovf_w2", 32'(overflow), 32'd0);
        drive(1'b0, 8'h00, 1'b1, 8'hBE);
        check_eq("ovf_w3", 32'(overflow), 32'd0);
        drive(1'b0, 8'h00, 1'b1, 8'hEF);
        check_eq("ovf_w4", 32'(overflow), 32'd0);
        drive(1'b0, 8'h00, 1'b1, 8'h55);
        check_eq("ovf_w5", 32'(overflow), 32'd2);
        check_eq("ovf_grant_held", 32'({busy, acc_ble_side}), 32'd3);
        @(negedge clk);
        check_eq("ovf_pulse", 32'(overflow), 32'd0);
        wait_cmd("ovf_src0", 200, cyc);
        chk_cmd("ovf_src0", 1'b0, 1'b0, 1'b0, 8'h02);
        wait_cmd("ovf_src1", 200, cyc);
        chk_cmd("ovf_src1", 1'b1, 1'b0, 1'b0, 8'h02);
        chk_log("ovf_b0", 1'b1, 8'h41);
        chk_log("ovf_b1", 1'b1, 8'h54);
        chk_log("ovf_b2", 1'b1, 8'h0D);
        chk_log("ovf_b3", 1'b0, 8'h01);
        chk_log("ovf_b4", 1'b0, 8'h02);
        chk_log("ovf_b5", 1'b0, 8'hBE);
        chk_log("ovf_b6", 1'b0, 8'hEF);
        check_eq("ovf_log_empty", 32'(log_q.size()), 32'd0);

        // Watchdog: single byte, done never rises
        drive(1'b1, 8'h41, 1'b0, 8'h00);
        cyc = 0;
        while (!acc_accumulate && cyc < 20) begin @(negedge clk); cyc++; end
        check_eq("wd_strobe_seen", 32'(acc_accumulate), 32'd1);
        cyc = 0;
        while (acc_accumulate && cyc < 20) begin @(negedge clk); cyc++; end
        check_eq("wd_strobe_end", 32'(acc_accumulate), 32'd0);
        wait_cmd("wd", 300, cyc);
        check_eq("wd_latency", 32'(cyc), 32'(GAP_CYCLES + WATCHDOG));
        chk_cmd("wd", 1'b0, 1'b1, 1'b1, 8'h00);
        check_eq("wd_busy_after", 32'(busy), 32'd0);

        // Reset mid-strobe
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        log_q.delete();
        drive(1'b1, 8'h41, 1'b0, 8'h00);
        drive(1'b1, 8'h54, 1'b0, 8'h00);
        drive(1'b0, 8'h00, 1'b1, 8'h01);
        check_eq("rms_strobe_high", 32'(acc_accumulate), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_eq("rms_async_accum", 32'(acc_accumulate), 32'd0);
        check_eq("rms_async_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        act = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (acc_accumulate || cmd_valid || busy) act++;
        end
        check_eq("rms_fifos_flushed", 32'(act), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
